// File: rtl/alu_word_sequencer.sv
// Sequences two or three 8-bit ALU passes to perform one 16-bit ADD/XOR/AND/EQ
// request, chaining the low-byte carry and returning the result over valid/ready.
module alu_word_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_carry,
    output logic        rsp_eq,
    output logic [2:0]  alu_cmd,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_sc_i,
    output logic        alu_neg_addi,
    input  logic [7:0]  alu_rslt,
    input  logic        alu_sc_o,
    input  logic        alu_zero
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_BEQ  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [1:0] OP_ADD16 = 2'b00;
    localparam logic [1:0] OP_XOR16 = 2'b01;
    localparam logic [1:0] OP_AND16 = 2'b10;
    localparam logic [1:0] OP_EQ16  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state;
    logic [1:0]          op;
    logic [WORD_W-1:0]   a;
    logic [WORD_W-1:0]   b;
    logic [WORD_W-1:0]   res;
    logic                c_lo;
    logic                c_hi;
    logic                c_fix;
    logic                z_lo;
    logic                z_hi;
    logic [2:0]          op_cmd;

    // Sequencer state and result capture; ALU outputs sampled at the edge ending each pass
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            op    <= 2'b00;
            a     <= '0;
            b     <= '0;
            res   <= '0;
            c_lo  <= 1'b0;
            c_hi  <= 1'b0;
            c_fix <= 1'b0;
            z_lo  <= 1'b0;
            z_hi  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op    <= req_op;
                        a     <= req_a;
                        b     <= req_b;
                        c_fix <= 1'b0;
                        state <= S_LO;
                    end
                end
                S_LO: begin
                    res[BYTE_W-1:0] <= alu_rslt;
                    c_lo            <= alu_sc_o;
                    z_lo            <= alu_zero;
                    state           <= S_HI;
                end
                S_HI: begin
                    res[WORD_W-1:BYTE_W] <= alu_rslt;
                    c_hi                 <= alu_sc_o;
                    z_hi                 <= alu_zero;
                    state                <= (op == OP_ADD16 && c_lo) ? S_FIX : S_DONE;
                end
                S_FIX: begin
                    res[WORD_W-1:BYTE_W] <= alu_rslt;
                    c_fix                <= alu_sc_o;
                    state                <= S_DONE;
                end
                S_DONE: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request opcode to ALU command
    always_comb begin
        op_cmd = ALU_ADD;
        case (op)
            OP_ADD16: op_cmd = ALU_ADD;
            OP_XOR16: op_cmd = ALU_XOR;
            OP_AND16: op_cmd = ALU_AND;
            OP_EQ16:  op_cmd = ALU_BEQ;
            default:  op_cmd = ALU_ADD;
        endcase
    end

    // ALU drive decoded from state and latched operands
    always_comb begin
        alu_cmd = ALU_PASS;
        alu_a   = '0;
        alu_b   = '0;
        case (state)
            S_LO: begin
                alu_cmd = op_cmd;
                alu_a   = a[BYTE_W-1:0];
                alu_b   = b[BYTE_W-1:0];
            end
            S_HI: begin
                alu_cmd = op_cmd;
                alu_a   = a[WORD_W-1:BYTE_W];
                alu_b   = b[WORD_W-1:BYTE_W];
            end
            S_FIX: begin
                alu_cmd = ALU_ADD;
                alu_a   = res[WORD_W-1:BYTE_W];
                alu_b   = 8'h01;
            end
            default: begin
                alu_cmd = ALU_PASS;
                alu_a   = '0;
                alu_b   = '0;
            end
        endcase
    end

    assign alu_sc_i     = 1'b0;
    assign alu_neg_addi = 1'b0;

    // req_ready is gated by reset so it reads 0 while reset is held
    assign req_ready = (state == S_IDLE) && !reset;
    assign rsp_valid = (state == S_DONE);
    assign rsp_data  = (rsp_valid && op != OP_EQ16) ? res : '0;
    assign rsp_carry = rsp_valid && (op == OP_ADD16) && (c_hi | c_fix);
    assign rsp_eq    = rsp_valid && (op == OP_EQ16) && z_lo && z_hi;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer with a behavioural 8-bit ALU model.
module tb_alu_word_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_eq;
    logic [2:0]  alu_cmd;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_sc_i;
    logic        alu_neg_addi;
    logic [7:0]  alu_rslt;
    logic        alu_sc_o;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;

    alu_word_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_carry    (rsp_carry),
        .rsp_eq       (rsp_eq),
        .alu_cmd      (alu_cmd),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sc_i     (alu_sc_i),
        .alu_neg_addi (alu_neg_addi),
        .alu_rslt     (alu_rslt),
        .alu_sc_o     (alu_sc_o),
        .alu_zero     (alu_zero)
    );

    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        logic [8:0] sum;
        sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_rslt = alu_a;
        alu_sc_o = 1'b0;
        alu_zero = 1'b0;
        case (alu_cmd)
            3'b000: begin alu_rslt = sum[7:0]; alu_sc_o = sum[8]; end
            3'b100: alu_rslt = alu_a ^ alu_b;
            3'b011: alu_rslt = alu_a & alu_b;
            3'b101: begin alu_rslt = alu_a - alu_b; alu_zero = (alu_a == alu_b); end
            default: alu_rslt = alu_a;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request (waiting for req_ready is not needed: caller is in IDLE) and step past the accept edge
    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Scramble the request bus; the sequencer must have latched already
        req_a = 16'hDEAD;
        req_b = 16'hBEEF;
        req_op = ~op;
    endtask

    // Count edges after accept until rsp_valid, recording the ALU commands seen
    task automatic wait_rsp(output int lat, output logic [2:0] cmd0, output logic [2:0] cmd1);
        lat  = 0;
        cmd0 = 3'bxxx;
        cmd1 = 3'bxxx;
        while (!rsp_valid && lat < 8) begin
            if (lat == 0) cmd0 = alu_cmd;
            if (lat == 1) cmd1 = alu_cmd;
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) begin
            errors++;
            checks++;
            $display("FAIL rsp_timeout: rsp_valid never rose within 8 cycles");
        end
    endtask

    task automatic check_rsp(input string tag, input logic [15:0] d, input logic c, input logic e);
        check({tag, "_data"},  32'(rsp_data),  32'(d));
        check({tag, "_carry"}, 32'(rsp_carry), 32'(c));
        check({tag, "_eq"},    32'(rsp_eq),    32'(e));
        check({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_done_cmd"},   32'(alu_cmd),   32'b111);
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] d, input logic c,
                          input logic e, input int exp_lat, input logic [2:0] exp_cmd);
        int lat;
        logic [2:0] c0, c1;
        issue(op, a, b);
        wait_rsp(lat, c0, c1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_cmd_lo"},  32'(c0),  32'(exp_cmd));
        check({tag, "_cmd_hi"},  32'(c1),  32'(exp_cmd));
        check_rsp(tag, d, c, e);
        release_rsp(tag);
    endtask

    initial begin
        int lat;
        logic [2:0] c0, c1;
        logic [15:0] hold_d;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_alu_cmd",   32'(alu_cmd),   32'b111);
        check("rst_alu_ab",    32'({alu_a, alu_b}), 32'd0);
        check("rst_const",     32'({alu_sc_i, alu_neg_addi}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // XOR16 with operand check during LO
        req_valid = 1'b1; req_op = 2'b01; req_a = 16'hA5A5; req_b = 16'h0FF0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("xor_lo_a", 32'(alu_a), 32'hA5);
        check("xor_lo_b", 32'(alu_b), 32'hF0);
        check("xor_lo_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("xor_hi_a", 32'(alu_a), 32'hA5);
        check("xor_hi_b", 32'(alu_b), 32'h0F);
        @(posedge clk); #1;
        check("xor_valid_lat2", 32'(rsp_valid), 32'd1);
        check_rsp("xor", 16'hAA55, 1'b0, 1'b0);
        release_rsp("xor");

        run_op("xor_cmd",   2'b01, 16'hA5A5, 16'h0FF0, 16'hAA55, 1'b0, 1'b0, 2, 3'b100);
        run_op("add_fix",   2'b00, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 3, 3'b000);
        run_op("add_hic",   2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 2, 3'b000);
        run_op("add_wrap",  2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 3, 3'b000);
        run_op("eq_same",   2'b11, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 2, 3'b101);
        run_op("eq_diff",   2'b11, 16'h1234, 16'h1334, 16'h0000, 1'b0, 1'b0, 2, 3'b101);
        run_op("and_plain", 2'b10, 16'hFF00, 16'h0FF0, 16'h0F00, 1'b0, 1'b0, 2, 3'b011);

        // Backpressure then a queued request
        issue(2'b00, 16'h1234, 16'h1111);
        wait_rsp(lat, c0, c1);
        check("bp_latency", 32'(lat), 32'd2);
        hold_d = rsp_data;
        check("bp_data", 32'(hold_d), 32'h2345);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_data",  32'(rsp_data),  32'h2345);
            check("bp_hold_flags", 32'({rsp_carry, rsp_eq}), 32'd0);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            check("bp_hold_cmd",   32'(alu_cmd),   32'b111);
        end
        req_valid = 1'b1; req_op = 2'b01; req_a = 16'hFFFF; req_b = 16'h1234;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        issue(2'b01, 16'hFFFF, 16'h1234);
        wait_rsp(lat, c0, c1);
        check("queued_latency", 32'(lat), 32'd2);
        check("queued_cmd", 32'(c0), 32'b100);
        check_rsp("queued", 16'hEDCB, 1'b0, 1'b0);
        release_rsp("queued");

        // Reset asserted during HI of an ADD16
        issue(2'b00, 16'h00FF, 16'h0001);
        @(posedge clk); #1;
        check("pre_rst_hi_cmd", 32'(alu_cmd), 32'b000);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd",   32'(alu_cmd),   32'b111);
        check("mid_rst_ab",    32'({alu_a, alu_b}), 32'd0);
        check("mid_rst_rsp",   32'({rsp_data, rsp_carry, rsp_eq}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rel_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rel_no_stale", 32'(rsp_valid), 32'd0);
        end
        run_op("and_after_rst", 2'b10, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 2, 3'b011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_word_sequencer.md
# alu_word_sequencer

Multi-cycle sequencer that drives the 8-bit datapath ALU to perform 16-bit operations on behalf of a requester. It accepts one 16-bit request over a valid/ready handshake and issues two or three 8-bit ALU passes, low byte first. It chains the carry, assembles the 16-bit result and returns it over a valid/ready response. It sits between the control unit and the ALU's command/operand/flag interface.

## Interface
- ALU_ADD, 3'b000, ALU add command (alu_neg_addi held 0)
- ALU_XOR, 3'b100, ALU bitwise-XOR command
- ALU_AND, 3'b011, ALU bitwise-AND command
- ALU_BEQ, 3'b101, ALU compare command (drives alu_zero)
- ALU_PASS, 3'b111, idle command (ALU passes inA)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  00 ADD16, 01 XOR16, 10 AND16, 11 EQ16
- req_a  in  16  operand A
- req_b  in  16  operand B
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  16  result (0 for EQ16)
- rsp_carry  out  1  ADD16 carry-out (0 for other ops)
- rsp_eq  out  1  EQ16 result, 1 = operands equal (0 for other ops)
- alu_cmd  out  3  ALU command
- alu_a, alu_b  out  8  ALU operands
- alu_sc_i  out  1  ALU shift carry-in, constant 0
- alu_neg_addi  out  1  ALU signed-immediate add select, constant 0
- alu_rslt  in  8  ALU result
- alu_sc_o  in  1  ALU carry-out
- alu_zero  in  1  ALU equality flag

## Operation
- States: IDLE, LO, HI, FIX, DONE.
- IDLE: req_ready=1. On req_valid, latch req_op/req_a/req_b and go to LO.
- LO: alu_cmd = op command (ADD16→ALU_ADD, XOR16→ALU_XOR, AND16→ALU_AND, EQ16→ALU_BEQ); alu_a=a[7:0], alu_b=b[7:0]. At the edge, capture alu_rslt→res[7:0], alu_sc_o→c_lo, alu_zero→z_lo. Then go to HI.
- HI: same command with a[15:8], b[15:8]. Capture alu_rslt→res[15:8], alu_sc_o→c_hi, alu_zero→z_hi.
  - If ADD16 and c_lo=1, go to FIX.
  - Otherwise go to DONE.
- FIX: alu_cmd=ALU_ADD, alu_a=res[15:8], alu_b=8'h01. Capture alu_rslt→res[15:8], alu_sc_o→c_fix. Go to DONE.
- DONE: rsp_valid=1. Outputs:
  - rsp_data=res, or 0 for EQ16.
  - rsp_carry = c_hi | c_fix for ADD16, else 0.
  - rsp_eq = z_lo & z_hi for EQ16, else 0.
  - On rsp_ready, go to IDLE.
- c_fix is cleared on every accept.
- In IDLE and DONE: alu_cmd=ALU_PASS, alu_a=alu_b=0.
- alu_sc_i and alu_neg_addi are 0 in every state.
- ALU outputs are decoded combinationally from the state and latched operands. ALU results are sampled only at the edge ending LO/HI/FIX.

## Timing
- Reset (async, any state, including mid-operation): state→IDLE, all latched operands/results/flags→0. Outputs while reset is high:
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_eq=0
  - alu_cmd=ALU_PASS, alu_a=0, alu_b=0
- In-flight operations are discarded; no response is produced.
- After reset deasserts, req_ready=1 from the first cycle.
- Accept at edge E0 (req_valid & req_ready).
  - LO occupies E0–E1, HI occupies E1–E2.
  - rsp_valid rises after E2; with FIX, after E3.
- Latency: 2 cycles (XOR16/AND16/EQ16, ADD16 without low carry), 3 cycles (ADD16 with low carry).
- req_ready=0 from the cycle after acceptance until the cycle after the response handshake. No same-cycle response-and-accept.
- rsp_valid/rsp_data/rsp_carry/rsp_eq are held stable while rsp_valid=1 and rsp_ready=0.
- req_* inputs are ignored outside IDLE. Changing them mid-operation has no effect.
- rsp_ready outside DONE is ignored.

## Test plan
- XOR16 0xA5A5^0x0FF0 → rsp_data=0xAA55, carry=0, eq=0, rsp_valid 2 cycles after accept; alu_cmd sequence 100,100.
- ADD16 0x00FF+0x0001 → FIX pass taken, rsp_data=0x0100, carry=0, latency 3; ADD16 0x8000+0x8000 → 0x0000, carry=1, latency 2.
- ADD16 0xFFFF+0x0001 → LO c=1, HI 0xFF, FIX 0xFF+1 → rsp_data=0x0000, carry=1, latency 3.
- EQ16 0x1234 vs 0x1234 → rsp_eq=1, rsp_data=0; EQ16 0x1234 vs 0x1334 (high byte differs) → rsp_eq=0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → response fields constant, req_ready=0, alu_cmd=111. Then rsp_ready=1 → next cycle req_ready=1, and a queued request is accepted.
- Assert reset during HI of an ADD16 → all outputs are zero/PASS immediately (async). After release, no stale rsp_valid appears, and a new AND16 0xF0F0&0x3C3C returns 0x3030.
